// File: rtl/mem_io_unit_pkg.sv
`default_nettype none
// ============================================================================
// mem_io_unit_pkg
// Shared FSM encoding and byte-split widths for the memory I/O unit.
// Revision: 1.0
// ============================================================================
package mem_io_unit_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_HI = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_io_unit.sv
`default_nettype none
// ============================================================================
// mem_io_unit
// Splits 12-bit core loads/stores into byte cycles on a synchronous SRAM.
// Revision: 1.0
// ============================================================================
module mem_io_unit
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req,
  input  logic              wren,
  input  logic              word,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              sram_en,
  output logic              sram_wren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [BYTE_W-1:0] sram_wdata,
  input  logic [BYTE_W-1:0] sram_rdata
);

  localparam int unsigned X_W = DATA_W - BYTE_W;

  state_t            state_q, state_d;
  logic              wren_q, wren_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] addr_inc;

  // Natural modulo-2^ADDR_W wrap carries the second byte across the page bit.
  assign addr_inc  = addr_q + ADDR_W'(1);
  assign read_data = rdata_q;

  always_comb begin
    state_d    = state_q;
    wren_d     = wren_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    lo_d       = lo_q;
    stall      = 1'b0;
    sram_en    = 1'b0;
    sram_wren  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall      = 1'b1;
          wren_d     = wren;
          word_d     = word;
          addr_d     = address;
          wdata_d    = write_data;
          sram_en    = 1'b1;
          sram_wren  = wren;
          sram_addr  = address;
          sram_wdata = wren ? write_data[BYTE_W-1:0] : '0;
          if (wren) state_d = word ? ST_WR_HI : ST_DONE;
          else      state_d = ST_RD_LO;
        end
      end
      ST_WR_HI: begin
        stall      = 1'b1;
        sram_en    = 1'b1;
        sram_wren  = 1'b1;
        sram_addr  = addr_inc;
        sram_wdata = {{(BYTE_W - X_W){wdata_q[DATA_W-1]}}, wdata_q[DATA_W-1:BYTE_W]};
        state_d    = ST_DONE;
      end
      ST_RD_LO: begin
        stall = 1'b1;
        lo_d  = sram_rdata;
        if (word_q) begin
          sram_en   = 1'b1;
          sram_addr = addr_inc;
          state_d   = ST_RD_HI;
        end else begin
          rdata_d = {{X_W{sram_rdata[BYTE_W-1]}}, sram_rdata};
          state_d = ST_DONE;
        end
      end
      ST_RD_HI: begin
        stall   = 1'b1;
        rdata_d = {sram_rdata[X_W-1:0], lo_q};
        state_d = ST_DONE;
      end
      // DONE deliberately ignores req so a held request is not re-issued.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      wren_q  <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_io_unit
// Scoreboard bench: expected SRAM cycles and completions are queued at issue.
// Revision: 1.0
// ============================================================================
module tb_mem_io_unit;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        req = 1'b0;
  logic        wren = 1'b0;
  logic        word = 1'b0;
  logic [16:0] address = '0;
  logic [11:0] write_data = '0;
  logic [11:0] read_data;
  logic        stall;
  logic        sram_en;
  logic        sram_wren;
  logic [16:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = '0;

  logic [7:0]  mem [0:131071];

  typedef struct {
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  wd;
  } op_t;

  typedef struct {
    logic [11:0] rd;
    int          lat;
  } comp_t;

  op_t   sram_q[$];
  comp_t comp_q[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    stall_cnt = 0;

  mem_io_unit #(.ADDR_W(17), .DATA_W(12)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .req       (req),
    .wren      (wren),
    .word      (word),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .stall     (stall),
    .sram_en   (sram_en),
    .sram_wren (sram_wren),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous SRAM: read data appears the cycle after an enabled read.
  always @(posedge clock) begin
    if (sram_en && sram_wren) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wren) sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    op_t   e;
    comp_t c;
    if (sram_en) begin
      if (sram_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_sram_cycle: got addr 0x%0h wren %0d, expected none", sram_addr, sram_wren);
      end else begin
        e = sram_q.pop_front();
        check("sram_wren", {31'd0, sram_wren}, {31'd0, e.wr});
        check("sram_addr", {15'd0, sram_addr}, {15'd0, e.addr});
        if (e.wr) check("sram_wdata", {24'd0, sram_wdata}, {24'd0, e.wd});
      end
    end
    if (stall) begin
      stall_cnt++;
    end else if (stall_cnt != 0) begin
      if (comp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_completion: got read_data 0x%0h, expected none", read_data);
      end else begin
        c = comp_q.pop_front();
        check("read_data", {20'd0, read_data}, {20'd0, c.rd});
        check("stall_cycles", stall_cnt, c.lat);
      end
      stall_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    if (stall) begin
      n_checks++;
      n_err++;
      $display("FAIL stall_timeout: got stall 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic issue(input logic w, input logic wd, input logic [16:0] a,
                       input logic [11:0] d, input logic [11:0] exp_rd, input int hold);
    op_t   o;
    comp_t c;
    o.wr   = w;
    o.addr = a;
    o.wd   = d[7:0];
    sram_q.push_back(o);
    if (wd) begin
      o.addr = a + 17'd1;
      o.wd   = {{4{d[11]}}, d[11:8]};
      sram_q.push_back(o);
    end
    c.rd  = exp_rd;
    c.lat = w ? (wd ? 2 : 1) : (wd ? 3 : 2);
    comp_q.push_back(c);
    @(posedge clock); #1;
    req = 1'b1; wren = w; word = wd; address = a; write_data = d;
    repeat (hold) begin @(posedge clock); #1; end
    // Scramble inputs so any use of unlatched values shows up.
    req = 1'b0; wren = ~w; word = ~wd; address = 17'h0ABCD; write_data = 12'h555;
    wait_idle();
  endtask

  initial begin
    op_t   o;
    comp_t c;
    repeat (2) @(posedge clock);
    #1;
    check("reset_stall",      {31'd0, stall},      32'd0);
    check("reset_sram_en",    {31'd0, sram_en},    32'd0);
    check("reset_sram_wren",  {31'd0, sram_wren},  32'd0);
    check("reset_sram_addr",  {15'd0, sram_addr},  32'd0);
    check("reset_sram_wdata", {24'd0, sram_wdata}, 32'd0);
    check("reset_read_data",  {20'd0, read_data},  32'd0);
    nreset = 1'b1;

    issue(1, 0, 17'h00100, 12'h0A5, 12'h000, 1);
    check("mem_00100", {24'd0, mem[17'h00100]}, 32'hA5);
    issue(1, 1, 17'h00200, 12'h8C3, 12'h000, 1);
    check("mem_00200", {24'd0, mem[17'h00200]}, 32'hC3);
    check("mem_00201", {24'd0, mem[17'h00201]}, 32'hF8);
    issue(0, 1, 17'h00200, 12'h000, 12'h8C3, 1);
    issue(1, 0, 17'h00300, 12'h080, 12'h8C3, 1);
    issue(1, 0, 17'h00301, 12'h07F, 12'h8C3, 1);
    issue(0, 0, 17'h00300, 12'h000, 12'hF80, 1);
    issue(0, 0, 17'h00301, 12'h000, 12'h07F, 1);
    issue(1, 1, 17'h1FFFF, 12'h3A5, 12'h07F, 1);
    check("mem_00000", {24'd0, mem[17'h00000]}, 32'h03);
    issue(0, 1, 17'h1FFFF, 12'h000, 12'h3A5, 1);
    issue(1, 1, 17'h00400, 12'h712, 12'h3A5, 1);
    issue(1, 0, 17'h00401, 12'h0E7, 12'h3A5, 1);
    issue(0, 1, 17'h00400, 12'h000, 12'h712, 1);
    issue(1, 0, 17'h00500, 12'h05C, 12'h712, 1);
    // req held through IDLE, RD_LO and DONE: a single read, no re-issue.
    issue(0, 0, 17'h00500, 12'h000, 12'h05C, 3);

    // Reset while in RD_HI abandons the load and clears read_data.
    o.wr = 1'b0; o.wd = 8'h00;
    o.addr = 17'h00200; sram_q.push_back(o);
    o.addr = 17'h00201; sram_q.push_back(o);
    c.rd = 12'h000; c.lat = 3; comp_q.push_back(c);
    @(posedge clock); #1;
    req = 1'b1; wren = 1'b0; word = 1'b1; address = 17'h00200;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b1;
    check("rst_mid_stall",     {31'd0, stall},     32'd0);
    check("rst_mid_sram_en",   {31'd0, sram_en},   32'd0);
    check("rst_mid_read_data", {20'd0, read_data}, 32'd0);

    issue(0, 0, 17'h00301, 12'h000, 12'h07F, 1);
    issue(0, 0, 17'h00401, 12'h000, 12'hFE7, 1);

    repeat (4) @(posedge clock);
    #1;
    check("sram_queue_empty", sram_q.size(), 32'd0);
    check("comp_queue_empty", comp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
